ysyx_22041207_mul_ctrl: RTL and testbench

//  EX-stage front end and back end for the RV64M multiply path, directly upstream and downstream of the iterative 64x64 multiplier.

---
 rtl/ysyx_22041207_mul_ctrl_pkg.sv | 59 +++++
 rtl/ysyx_22041207_mul_opcond.sv | 31 +++
 rtl/ysyx_22041207_mul_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_ysyx_22041207_mul_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041207_mul_ctrl_pkg.sv
// Shared types and helpers for the RV64M multiply controller.
package ysyx_22041207_mul_ctrl_pkg;

  localparam int MUL_XLEN = 64;
  localparam int ACC_W    = 128;

  // Opcode encodings as presented on req_op.
  typedef enum logic [2:0] {
    MUL_OP_MUL    = 3'b000,
    MUL_OP_MULH   = 3'b001,
    MUL_OP_MULHSU = 3'b010,
    MUL_OP_MULHU  = 3'b011,
    MUL_OP_MULW   = 3'b100
  } mul_op_e;

  // Controller FSM states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_FIX   = 3'd3,
    ST_RESP  = 3'd4
  } mul_state_e;

  // Map a raw opcode onto the supported set; unknown codes run as MUL.
  function automatic mul_op_e mul_op_decode(input logic [2:0] raw);
    case (raw)
      3'b001:  return MUL_OP_MULH;
      3'b010:  return MUL_OP_MULHSU;
      3'b011:  return MUL_OP_MULHU;
      3'b100:  return MUL_OP_MULW;
      default: return MUL_OP_MUL;
    endcase
  endfunction

  // High-half variants are built from four 32x32 sub-products.
  function automatic logic op_is_high(input mul_op_e op);
    return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU) || (op == MUL_OP_MULHU);
  endfunction

  // Left shift applied to sub-product k before accumulation.
  function automatic logic [6:0] subop_shift(input logic [1:0] k);
    case (k)
      2'd0:    return 7'd0;
      2'd3:    return 7'd64;
      default: return 7'd32;
    endcase
  endfunction

  // Select the rd value out of the 128-bit accumulator.
  function automatic logic [63:0] mul_result(input mul_op_e op, input logic [127:0] acc);
    case (op)
      MUL_OP_MULW: return {{32{acc[31]}}, acc[31:0]};
      MUL_OP_MUL:  return acc[63:0];
      default:     return acc[127:64];
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22041207_mul_opcond.sv
// Operand conditioning: magnitudes and result sign for the signed variants.
// Unsigned operands pass through untouched, so MUL/MULW get raw values.
module ysyx_22041207_mul_opcond
  import ysyx_22041207_mul_ctrl_pkg::*;
(
  input  mul_op_e     op,
  input  logic [63:0] src1,
  input  logic [63:0] src2,
  output logic [63:0] mag1,
  output logic [63:0] mag2,
  output logic        neg
);

  logic sgn1_s;
  logic sgn2_s;
  logic neg1_s;
  logic neg2_s;

  // Decide signedness per operand and take two's-complement magnitudes.
  always_comb begin
    sgn1_s = (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
    sgn2_s = (op == MUL_OP_MULH);
    neg1_s = sgn1_s & src1[63];
    neg2_s = sgn2_s & src2[63];
    // -2^63 negates to itself, which read unsigned is exactly 2^63.
    mag1   = neg1_s ? (~src1 + 64'd1) : src1;
    mag2   = neg2_s ? (~src2 + 64'd1) : src2;
    neg    = neg1_s ^ neg2_s;
  end

endmodule

// File: rtl/ysyx_22041207_mul_ctrl.sv
// EX-stage controller around the iterative 64x64 multiplier: conditions
// operands, sequences sub-products, accumulates, sign-fixes, responds.
module ysyx_22041207_mul_ctrl
  import ysyx_22041207_mul_ctrl_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [XLEN-1:0]  req_src1,
  input  logic [XLEN-1:0]  req_src2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_data,
  output logic [TAG_W-1:0] resp_tag,
  input  logic             flush,
  output logic             m_valid,
  output logic             m_flush,
  output logic [63:0]      m_a,
  output logic [63:0]      m_b,
  input  logic             m_ready,
  input  logic             m_out_valid,
  input  logic [31:0]      m_res_hi,
  input  logic [31:0]      m_res_lo
);

  mul_state_e       state_q, state_d;
  mul_op_e          op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [63:0]      a_q, a_d;
  logic [63:0]      b_q, b_d;
  logic             neg_q, neg_d;
  logic [1:0]       k_q, k_d;
  logic [127:0]     acc_q, acc_d;
  logic             resp_valid_q, resp_valid_d;
  logic [63:0]      resp_data_q, resp_data_d;
  logic [TAG_W-1:0] resp_tag_q, resp_tag_d;

  mul_op_e          req_op_s;
  logic [63:0]      mag1_s;
  logic [63:0]      mag2_s;
  logic             neg_s;
  logic [127:0]     prod_s;

  assign req_op_s = mul_op_decode(req_op);

  ysyx_22041207_mul_opcond u_opcond (
    .op   (req_op_s),
    .src1 (req_src1),
    .src2 (req_src2),
    .mag1 (mag1_s),
    .mag2 (mag2_s),
    .neg  (neg_s)
  );

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_tag   = resp_tag_q;
  assign prod_s     = {64'd0, m_res_hi, m_res_lo};

  // Multiplier operands for the current sub-op: raw for MUL/MULW, halves otherwise.
  always_comb begin
    m_a = a_q;
    m_b = b_q;
    if (op_is_high(op_q)) begin
      case (k_q)
        2'd0: begin m_a = {32'd0, a_q[31:0]};  m_b = {32'd0, b_q[31:0]};  end
        2'd1: begin m_a = {32'd0, a_q[31:0]};  m_b = {32'd0, b_q[63:32]}; end
        2'd2: begin m_a = {32'd0, a_q[63:32]}; m_b = {32'd0, b_q[31:0]};  end
        default: begin m_a = {32'd0, a_q[63:32]}; m_b = {32'd0, b_q[63:32]}; end
      endcase
    end else begin
      m_a = a_q;
      m_b = b_q;
    end
  end

  // Next-state, datapath updates and multiplier handshake; flush overrides all.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    tag_d        = tag_q;
    a_d          = a_q;
    b_d          = b_q;
    neg_d        = neg_q;
    k_d          = k_q;
    acc_d        = acc_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_tag_d   = resp_tag_q;
    m_valid      = 1'b0;
    m_flush      = 1'b0;

    if (flush && (state_q != ST_IDLE)) begin
      m_flush      = 1'b1;
      state_d      = ST_IDLE;
      resp_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A flush in IDLE blocks acceptance without signalling the multiplier.
          if (req_valid && !flush) begin
            op_d    = req_op_s;
            tag_d   = req_tag;
            a_d     = mag1_s;
            b_d     = mag2_s;
            neg_d   = neg_s;
            k_d     = 2'd0;
            acc_d   = 128'd0;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ISSUE: begin
          m_valid = 1'b1;
          if (m_ready) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_ISSUE;
          end
        end
        ST_WAIT: begin
          if (m_out_valid) begin
            acc_d = acc_q + (prod_s << subop_shift(k_q));
            if (op_is_high(op_q) && (k_q != 2'd3)) begin
              k_d     = k_q + 2'd1;
              state_d = ST_ISSUE;
            end else if (op_is_high(op_q)) begin
              state_d = ST_FIX;
            end else begin
              state_d      = ST_RESP;
              resp_valid_d = 1'b1;
              resp_data_d  = mul_result(op_q, acc_d);
              resp_tag_d   = tag_q;
            end
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_FIX: begin
          if (neg_q) begin
            acc_d = ~acc_q + 128'd1;
          end else begin
            acc_d = acc_q;
          end
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_data_d  = mul_result(op_q, acc_d);
          resp_tag_d   = tag_q;
        end
        ST_RESP: begin
          if (resp_ready) begin
            state_d      = ST_IDLE;
            resp_valid_d = 1'b0;
          end else begin
            state_d = ST_RESP;
          end
        end
        default: begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      op_q         <= MUL_OP_MUL;
      tag_q        <= '0;
      a_q          <= 64'd0;
      b_q          <= 64'd0;
      neg_q        <= 1'b0;
      k_q          <= 2'd0;
      acc_q        <= 128'd0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 64'd0;
      resp_tag_q   <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      tag_q        <= tag_d;
      a_q          <= a_d;
      b_q          <= b_d;
      neg_q        <= neg_d;
      k_q          <= k_d;
      acc_q        <= acc_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_tag_q   <= resp_tag_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22041207_mul_ctrl.sv
// Self-checking bench for ysyx_22041207_mul_ctrl with a behavioural multiplier.
module tb_ysyx_22041207_mul_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [63:0] req_src1 = 64'd0;
  logic [63:0] req_src2 = 64'd0;
  logic [4:0]  req_tag = 5'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_data;
  logic [4:0]  resp_tag;
  logic        flush = 1'b0;
  logic        m_valid;
  logic        m_flush;
  logic [63:0] m_a;
  logic [63:0] m_b;
  logic        m_ready;
  logic        m_out_valid;
  logic [31:0] m_res_hi;
  logic [31:0] m_res_lo;

  int total = 0;
  int passed = 0;
  int hs_cnt = 0;
  int lat_lo = 0;
  int lat_hi = 3;

  ysyx_22041207_mul_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_tag(resp_tag),
    .flush(flush), .m_valid(m_valid), .m_flush(m_flush),
    .m_a(m_a), .m_b(m_b), .m_ready(m_ready), .m_out_valid(m_out_valid),
    .m_res_hi(m_res_hi), .m_res_lo(m_res_lo)
  );

  always #5 clk = ~clk;

  // Behavioural iterative multiplier: low 64 bits of a*b after a random delay.
  logic        mbusy;
  int          mcnt;
  logic [63:0] mprod;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ready <= 1'b1; m_out_valid <= 1'b0; mbusy <= 1'b0; mcnt <= 0;
      mprod <= 64'd0; m_res_hi <= 32'd0; m_res_lo <= 32'd0;
    end else begin
      m_out_valid <= 1'b0;
      if (m_flush) begin
        mbusy <= 1'b0; m_ready <= 1'b1;
      end else if (mbusy) begin
        if (mcnt == 0) begin
          mbusy <= 1'b0; m_out_valid <= 1'b1;
          m_res_hi <= mprod[63:32]; m_res_lo <= mprod[31:0];
        end else begin
          mcnt <= mcnt - 1;
        end
      end else if (m_valid && m_ready) begin
        mbusy <= 1'b1; m_ready <= 1'b0; mprod <= m_a * m_b;
        mcnt <= $urandom_range(lat_hi, lat_lo);
      end else begin
        m_ready <= 1'b1;
      end
    end
  end

  // Count multiplier request handshakes.
  always @(posedge clk) begin
    if (rst && m_valid && m_ready) hs_cnt <= hs_cnt + 1;
  end

  // Reference: RV64M semantics from full 128-bit products.
  function automatic logic [63:0] ref_mul(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] sa, sb, za, zb, p;
    sa = {{64{a[63]}}, a}; sb = {{64{b[63]}}, b};
    za = {64'd0, a};       zb = {64'd0, b};
    case (op)
      3'd1: begin p = sa * sb; return p[127:64]; end
      3'd2: begin p = sa * zb; return p[127:64]; end
      3'd3: begin p = za * zb; return p[127:64]; end
      3'd4: begin p = za * zb; return {{32{p[31]}}, p[31:0]}; end
      default: begin p = za * zb; return p[63:0]; end
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
  endtask

  task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b; req_tag = tag;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (resp_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic do_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] tag, input int delay,
                       output logic [63:0] data, output logic [4:0] tg);
    logic ok;
    issue(op, a, b, tag);
    wait_resp(ok);
    if (ok) begin
      repeat (delay) @(negedge clk);
      data = resp_data; tg = resp_tag;
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
    end else begin
      $display("FAIL resp_timeout: got no resp_valid, expected resp_valid within 400 cycles");
      data = 64'hx; tg = 5'hx;
    end
  endtask

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(5, 0))
      0: return 64'd0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'd1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  typedef struct {
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  tag;
    logic [63:0] exp;
    int          hs;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [63:0] d, d0;
    logic [4:0]  t;
    logic        ok, stable;
    logic [2:0]  rop;
    logic [63:0] ra, rb;
    logic [4:0]  rtag;

    vecs[0] = '{3'd0, 64'd3, 64'd5, 5'd7, 64'd15, 1};
    vecs[1] = '{3'd4, 64'h7FFF_FFFF, 64'd2, 5'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1};
    vecs[2] = '{3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE, 4};
    vecs[3] = '{3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 4};
    vecs[4] = '{3'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd4, 64'h4000_0000_0000_0000, 4};
    vecs[5] = '{3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 4};
    vecs[6] = '{3'd2, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6, 64'd4, 4};
    vecs[7] = '{3'd7, 64'd6, 64'd7, 5'd31, 64'd42, 1};
    vecs[8] = '{3'd1, 64'h8000_0000_0000_0000, 64'd1, 5'd8, 64'hFFFF_FFFF_FFFF_FFFF, 4};
    vecs[9] = '{3'd4, 64'hFFFF_FFFF, 64'd3, 5'd9, 64'hFFFF_FFFF_FFFF_FFFD, 1};

    // Reset state
    #1;
    check("rst_req_ready", {63'd0, req_ready}, 64'd1);
    check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_m_valid", {63'd0, m_valid}, 64'd0);
    check("rst_m_flush", {63'd0, m_flush}, 64'd0);
    check("rst_resp_data", resp_data, 64'd0);
    check("rst_resp_tag", {59'd0, resp_tag}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Directed vectors
    for (int i = 0; i < 10; i++) begin
      hs_cnt = 0;
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, i % 3, d, t);
      check($sformatf("vec%0d_data", i), d, vecs[i].exp);
      check($sformatf("vec%0d_tag", i), {59'd0, t}, {59'd0, vecs[i].tag});
      check($sformatf("vec%0d_handshakes", i), 64'(hs_cnt), 64'(vecs[i].hs));
      check($sformatf("vec%0d_resp_drop", i), {63'd0, resp_valid}, 64'd0);
    end

    // Random operations against the reference model
    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(7, 0));
      ra = pick_operand(); rb = pick_operand(); rtag = 5'($urandom);
      do_op(rop, ra, rb, rtag, $urandom_range(3, 0), d, t);
      check($sformatf("rand%0d_op%0d_data", i, rop), d, ref_mul(rop, ra, rb));
      check($sformatf("rand%0d_tag", i), {59'd0, t}, {59'd0, rtag});
    end

    // Backpressure: hold resp_ready low for 10 cycles
    issue(3'd3, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 5'd12);
    wait_resp(ok);
    check("bp_resp_seen", {63'd0, ok}, 64'd1);
    d0 = resp_data; stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!resp_valid || resp_data !== d0 || resp_tag !== 5'd12) stable = 1'b0;
    end
    check("bp_stable", {63'd0, stable}, 64'd1);
    check("bp_data", d0, ref_mul(3'd3, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321));
    resp_ready = 1'b1; @(negedge clk); resp_ready = 1'b0;
    check("bp_released", {63'd0, resp_valid}, 64'd0);

    // Flush during WAIT of sub-op 2
    lat_lo = 3; lat_hi = 3; hs_cnt = 0;
    issue(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0003_0000_0005, 5'd20);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (hs_cnt == 3 && !m_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("flush_reached_subop2", {63'd0, ok}, 64'd1);
    flush = 1'b1; #1;
    check("flush_m_flush", {63'd0, m_flush}, 64'd1);
    check("flush_m_valid", {63'd0, m_valid}, 64'd0);
    @(negedge clk); flush = 1'b0; #1;
    check("flush_idle", {63'd0, req_ready}, 64'd1);
    check("flush_m_flush_one_cycle", {63'd0, m_flush}, 64'd0);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid) stable = 1'b0;
    end
    check("flush_no_resp", {63'd0, stable}, 64'd1);
    lat_lo = 0; lat_hi = 3;
    do_op(3'd0, 64'd6, 64'd7, 5'd9, 0, d, t);
    check("post_flush_mul", d, 64'd42);

    // Flush in IDLE blocks a simultaneous request and does not reach the multiplier
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_op = 3'd0; req_src1 = 64'd2; req_src2 = 64'd2; #1;
    check("idle_flush_no_m_flush", {63'd0, m_flush}, 64'd0);
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0; #1;
    check("idle_flush_not_accepted", {63'd0, req_ready}, 64'd1);

    // Flush while a response is pending drops it
    issue(3'd0, 64'd9, 64'd9, 5'd1);
    wait_resp(ok);
    flush = 1'b1; @(negedge clk); flush = 1'b0; #1;
    check("resp_flush_dropped", {63'd0, resp_valid}, 64'd0);
    check("resp_flush_idle", {63'd0, req_ready}, 64'd1);

    // Asynchronous reset while a response is held
    issue(3'd0, 64'd3, 64'd5, 5'd7);
    wait_resp(ok);
    check("arst_pre_data", resp_data, 64'd15);
    #2 rst = 1'b0; #1;
    check("arst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("arst_resp_data", resp_data, 64'd0);
    check("arst_resp_tag", {59'd0, resp_tag}, 64'd0);
    check("arst_req_ready", {63'd0, req_ready}, 64'd1);
    check("arst_m_valid", {63'd0, m_valid}, 64'd0);
    @(negedge clk); rst = 1'b1;
    do_op(3'd4, 64'h7FFF_FFFF, 64'd2, 5'd3, 1, d, t);
    check("arst_recover_mulw", d, 64'hFFFF_FFFF_FFFF_FFFE);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
